// File: rtl/logisim_tick_clock.sv
// Tick-driven derived clock generator with run/halt/single-step control.
// ClockOut advances one half-period count per consumed FPGATick; RiseEn and
// FallEn mark the FPGAClock cycle in which ClockOut changes level.
// Optional feature: define LOGISIM_TICK_CLOCK_EDGECOUNT_EN to add a 16-bit
// EdgeCount output counting rising edges since reset.
module logisim_tick_clock #(
    parameter int HighTicks = 2,
    parameter int LowTicks  = 2,
    parameter int Phase     = 1,
    parameter int NrOfBits  = 8
) (
    input  logic        FPGAClock,
    input  logic        FPGAResetN,
    input  logic        FPGATick,
    input  logic        run,
    input  logic        step,
    output logic        ClockOut,
    output logic        RiseEn,
    output logic        FallEn,
`ifdef LOGISIM_TICK_CLOCK_EDGECOUNT_EN
    output logic [15:0] EdgeCount,
`endif
    output logic        Running
);

    // Zero-length half-periods behave as one tick; the first low phase is
    // clamped into 1..LowTicks.
    localparam int HT = (HighTicks < 1) ? 1 : HighTicks;
    localparam int LT = (LowTicks  < 1) ? 1 : LowTicks;
    localparam int PH = (Phase < 1) ? 1 : ((Phase > LT) ? LT : Phase);

    localparam logic [NrOfBits-1:0] HT_LAST = NrOfBits'(HT - 1);
    localparam logic [NrOfBits-1:0] LT_LAST = NrOfBits'(LT - 1);
    localparam logic [NrOfBits-1:0] PH_LAST = NrOfBits'(PH - 1);

    typedef enum logic [1:0] {
        HALT = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_nstate;
    logic [NrOfBits-1:0]   r_cnt;
    logic                  r_clk;
    logic                  r_rise;
    logic                  r_fall;
    logic                  r_first;

    logic                  w_tick;
    logic                  w_last;
    logic                  w_edge;
    logic [NrOfBits-1:0]   w_limit_last;

    // Ticks only count while the registered state is active.
    assign w_tick       = (r_state != HALT) && FPGATick;
    assign w_limit_last = r_clk ? HT_LAST : (r_first ? PH_LAST : LT_LAST);
    assign w_last       = (r_cnt == w_limit_last);
    assign w_edge       = w_tick && w_last;

    // Next-state logic: run dominates step; STEP drops to HALT on its edge.
    always_comb begin
        w_nstate = r_state;
        unique case (r_state)
            HALT: begin
                if (run)       w_nstate = RUN;
                else if (step) w_nstate = STEP;
            end
            RUN: begin
                if (!run)      w_nstate = HALT;
            end
            STEP: begin
                if (run)         w_nstate = RUN;
                else if (w_edge) w_nstate = HALT;
            end
            default: w_nstate = HALT;
        endcase
    end

    // State register.
    always_ff @(posedge FPGAClock) begin
        if (!FPGAResetN) r_state <= HALT;
        else             r_state <= w_nstate;
    end

    // Half-period counter, derived clock level and one-cycle edge strobes.
    always_ff @(posedge FPGAClock) begin
        if (!FPGAResetN) begin
            r_cnt   <= '0;
            r_clk   <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_first <= 1'b1;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (w_tick) begin
                if (w_last) begin
                    r_cnt  <= '0;
                    r_clk  <= ~r_clk;
                    r_rise <= ~r_clk;
                    r_fall <= r_clk;
                    if (!r_clk) r_first <= 1'b0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

`ifdef LOGISIM_TICK_CLOCK_EDGECOUNT_EN
    logic [15:0] r_edge_cnt;

    // Rising-edge counter, wraps naturally at 16 bits.
    always_ff @(posedge FPGAClock) begin
        if (!FPGAResetN)           r_edge_cnt <= '0;
        else if (w_edge && !r_clk) r_edge_cnt <= r_edge_cnt + 16'd1;
    end

    assign EdgeCount = r_edge_cnt;
`endif

    assign ClockOut = r_clk;
    assign RiseEn   = r_rise;
    assign FallEn   = r_fall;
    assign Running  = (r_state != HALT);

endmodule

// File: doc/logisim_tick_clock.md
LOGISIM_TICK_CLOCK -- requirements
Module: logisim_tick_clock

Interface
REQ-001 SHALL have parameter HighTicks, default 2: ticks per high half-period; value 0 treated as 1.
REQ-002 SHALL have parameter LowTicks, default 2: ticks per low half-period; value 0 treated as 1.
REQ-003 SHALL have parameter Phase, default 1: low ticks before the first rising edge after reset; clamped to 1..LowTicks.
REQ-004 SHALL have parameter NrOfBits, default 8: half-period counter width; SHALL hold max(HighTicks,LowTicks).
REQ-005 SHALL have port FPGAClock  in  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port FPGAResetN  in  1  reset, synchronous, active-low.
REQ-007 SHALL have port FPGATick  in  1  tick enable from the tick generator; one tick per cycle it is high.
REQ-008 SHALL have port run  in  1  level; 1 = free-run, 0 = halt.
REQ-009 SHALL have port step  in  1  single-cycle request to advance to the next ClockOut edge while halted.
REQ-010 SHALL have port ClockOut  out  1  registered derived clock level.
REQ-011 SHALL have port RiseEn  out  1  one-FPGAClock-cycle pulse, same cycle ClockOut goes 0->1.
REQ-012 SHALL have port FallEn  out  1  one-FPGAClock-cycle pulse, same cycle ClockOut goes 1->0.
REQ-013 SHALL have port Running  out  1  high while state is RUN or STEP.

Function
REQ-014 SHALL implement states HALT, RUN, STEP; state, counter and outputs all registered.
REQ-015 A tick SHALL be consumed only in cycles where registered state is RUN or STEP and FPGATick=1; FPGATick is level-sampled, no edge detection.
REQ-016 In HALT, ticks SHALL be ignored; counter and ClockOut hold.
REQ-017 HALT->RUN when run=1; RUN->HALT when run=0; change takes effect next cycle; a tick in the cycle run falls is still consumed.
REQ-018 HALT->STEP when step=1 and run=0; run=1 wins if both high; step ignored in RUN and STEP.
REQ-019 STEP SHALL consume ticks as RUN until the next ClockOut edge, then return to HALT the same cycle that edge appears; run=1 in STEP moves to RUN instead.
REQ-020 Low phase: on a consumed tick with counter = limit-1 (limit = Phase for the first low phase after reset, else LowTicks), next cycle ClockOut=1, RiseEn=1, counter=0; otherwise counter increments.
REQ-021 High phase: on a consumed tick with counter = HighTicks-1, next cycle ClockOut=0, FallEn=1, counter=0; otherwise counter increments.
REQ-022 Latency tick-to-edge SHALL be exactly one FPGAClock cycle; RiseEn and FallEn SHALL never be high together and SHALL be 0 in cycles with no edge.
REQ-023 With HighTicks=LowTicks=1 and FPGATick held high in RUN, ClockOut SHALL toggle every cycle.
REQ-024 Counter SHALL never exceed limit-1; no wrap-around past the limit.

Reset
REQ-025 When FPGAResetN=0 at a rising FPGAClock: state=HALT, ClockOut=0, RiseEn=0, FallEn=0, Running=0, counter=0, first-phase flag set; overrides run, step and FPGATick.
REQ-026 Reset mid-half-period SHALL discard partial count; no edge pulse SHALL be generated by reset.

Configuration
REQ-027 Macro LOGISIM_TICK_CLOCK_EDGECOUNT_EN SHALL, when defined, add output EdgeCount (16 bits): count of RiseEn pulses since reset, wraps 0xFFFF->0x0000, reset to 0.
REQ-028 Without LOGISIM_TICK_CLOCK_EDGECOUNT_EN, port EdgeCount and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-029 Reset, run=1, FPGATick high every cycle, HighTicks=LowTicks=2, Phase=1 -> first RiseEn 2 cycles after the first tick, then ClockOut period 4 cycles, duty 2/2.
REQ-030 run=1, FPGATick one cycle in 4, HighTicks=3, LowTicks=1 -> ClockOut high 12 cycles, low 4 cycles; RiseEn/FallEn each one cycle wide.
REQ-031 Halted with ClockOut=0, pulse step with tick every cycle, LowTicks=2 -> exactly one RiseEn, Running 1 then 0, ClockOut stays 1, later ticks ignored.
REQ-032 run dropped in the cycle a final low tick arrives -> edge still produced next cycle, then HALT; run=1 and step=1 together in HALT -> RUN.
REQ-033 FPGAResetN low for one cycle mid-high-phase -> next cycle ClockOut=0, no FallEn, Running=0.
REQ-034 With LOGISIM_TICK_CLOCK_EDGECOUNT_EN, 65537 rising edges -> EdgeCount=1; without macro, build has no EdgeCount port.
